// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type and default sizes for the serial adder
package adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width that stays legal when only one step is needed.
    function automatic int cnt_bits(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/adder_serial_if.sv
// rtl/adder_serial_if.sv - request/result bundle for adder_serial (sub present with ADDER_SUB_EN)
interface adder_serial_if #(
    parameter int WIDTH = adder_pkg::DEF_WIDTH
);
    import adder_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

`ifdef ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, overflow);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, overflow);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, overflow);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, overflow);
`endif

endinterface

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple adder built from full-adder cells
module digit_adder
    import adder_pkg::*;
#(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT - 1];

endmodule

// File: rtl/adder_serial.sv
// rtl/adder_serial.sv - digit-serial adder, WIDTH/DIGIT cycles per op; ADDER_SUB_EN adds a-b
module adder_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic           clk,
    input  logic           rst,
    adder_serial_if.slave  bus
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_bits(STEPS);

    state_t           state, state_nx;
    logic             capture, last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, acc, acc_nx;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [DIGIT-1:0] dsum;
    logic             dcout, dcmsb;

`ifdef ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the inversion and forced carry happen at capture.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    capture  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(STEPS - 1)) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                capture  = bus.start;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_sr[DIGIT-1:0]),
        .b    (b_sr[DIGIT-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // New digit enters at the MSB so after STEPS shifts the word is in place.
    assign acc_nx = WIDTH'({dsum, acc} >> DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (capture) begin
            cnt   <= '0;
            a_sr  <= bus.a;
            b_sr  <= b_eff;
            acc   <= '0;
            carry <= cin_eff;
        end else if (state == RUN) begin
            cnt   <= cnt + CW'(1);
            a_sr  <= a_sr >> DIGIT;
            b_sr  <= b_sr >> DIGIT;
            acc   <= acc_nx;
            carry <= dcout;
            if (last) begin
                sum_q  <= acc_nx;
                cout_q <= dcout;
                ovf_q  <= dcmsb ^ dcout;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_adder_serial.sv
// tb/tb_adder_serial.sv - self-checking bench for adder_serial, WIDTH=8 DIGIT=2 (ADDER_SUB_EN optional)
module tb_adder_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    adder_serial_if #(.WIDTH(8)) bus ();

    adder_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        res_t       exp;
    } vec_t;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        int   bb, c, u, sa, sb, s;
        bb = sub ? (255 - int'(b)) : int'(b);
        c  = sub ? 1 : int'(cin);
        u  = int'(a) + bb + c;
        sa = (a >= 8'h80) ? int'(a) - 256 : int'(a);
        sb = (bb >= 128) ? bb - 256 : bb;
        s  = sa + sb + c;
        r.sum  = u[7:0];
        r.cout = (u > 255);
        r.ovf  = (s > 127) || (s < -128);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef ADDER_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: sub request ignored in add-only build");
`endif
    endtask

    // lat counts clocks since the start edge; bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(input int k0, output int lat, output int nbusy);
        lat   = k0;
        nbusy = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input res_t exp);
        int lat, nb;
        @(negedge clk);
        drive(a, b, cin, sub);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1, lat, nb);
        chk({name, "_latency"}, lat, 5);
        chk({name, "_busy_cycles"}, nb, 4);
        chk({name, "_sum"}, bus.sum, exp.sum);
        chk({name, "_cout"}, bus.cout, exp.cout);
        chk({name, "_ovf"}, bus.overflow, exp.ovf);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, bus.done, 1'b0);
    endtask

    initial begin
        vec_t vq[$];
        vec_t v;
        int   lat, nb;
        bit   seen;
        logic [7:0] ra, rb;
        logic       rc, rs;

        bus.start = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_sum", bus.sum, 8'h00);
        chk("rst_cout", bus.cout, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);
        rst = 1'b0;

        vq.push_back('{"add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, '{8'h96, 1'b0, 1'b1}});
        vq.push_back('{"add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0}});
        vq.push_back('{"add_cin", 8'h00, 8'h00, 1'b1, 1'b0, '{8'h01, 1'b0, 1'b0}});
        vq.push_back('{"add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}});
`ifdef ADDER_SUB_EN
        vq.push_back('{"sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, '{8'hF0, 1'b0, 1'b0}});
        vq.push_back('{"sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, '{8'h7F, 1'b1, 1'b1}});
`endif
        foreach (vq[i]) begin
            v = vq[i];
            do_op(v.name, v.a, v.b, v.cin, v.sub, v.exp);
        end

        // Second start during RUN must not disturb the operation in flight.
        @(negedge clk);
        drive(8'h11, 8'h22, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        drive(8'hFF, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2, lat, nb);
        chk("ignore_latency", lat, 5);
        chk("ignore_sum", bus.sum, 8'h33);
        @(negedge clk);

        // Reset on the second RUN cycle aborts without a done pulse.
        drive(8'h5A, 8'h3C, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_sum", bus.sum, 8'h00);
        chk("abort_cout", bus.cout, 1'b0);
        chk("abort_ovf", bus.overflow, 1'b0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        do_op("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, '{8'h02, 1'b0, 1'b0});

        // Back-to-back: start held high through the first done.
        @(negedge clk);
        drive(8'h10, 8'h05, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        wait_done(1, lat, nb);
        chk("b2b_first_latency", lat, 5);
        chk("b2b_first_sum", bus.sum, 8'h15);
        drive(8'h70, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_no_idle", bus.busy, 1'b1);
        wait_done(1, lat, nb);
        chk("b2b_done_gap", lat, 5);
        chk("b2b_second_sum", bus.sum, 8'h80);
        chk("b2b_second_ovf", bus.overflow, 1'b1);
        chk("b2b_second_cout", bus.cout, 1'b0);
        @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op($sformatf("rand%0d", n), ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
